// File: rtl/vote_sweep.sv
// vote_sweep: N-input minority/majority voter with a built-in exhaustive sweep.
// A sweep walks every N-bit vector from 0 to 2^N-1, emits one vote per cycle
// and tallies how many vectors voted 1. In IDLE a single external vector can
// be evaluated instead, with one cycle of latency.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting; start launches a sweep, ext_valid evaluates ext_vec
// S_SWEEP | one vector per cycle, counter 0 .. 2^N-1, tally accumulates
// S_DONE  | single cycle after the last result; done/y_valid fall, then IDLE
module vote_sweep #(
    parameter int N  = 3,
    parameter int CW = N + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          ext_valid,
    input  logic [N-1:0]  ext_vec,
    output logic          busy,
    output logic          done,
    output logic          y_valid,
    output logic [N-1:0]  vec_out,
    output logic          y_out,
    output logic [CW-1:0] ones_count
);

    // Width of a popcount of N bits and the minority threshold T = (N-1)/2.
    localparam int            PW     = $clog2(N + 1);
    localparam logic [PW-1:0] C_T    = PW'((N - 1) / 2);
    // Counter is one bit wider than a vector so the terminal compare is exact.
    localparam logic [N:0]    C_LAST = {1'b0, {N{1'b1}}};
    localparam logic [N:0]    C_ONE  = {{N{1'b0}}, 1'b1};

    generate
        if (N < 3 || N > 15 || (N % 2) == 0) begin : g_bad_n
            $error("vote_sweep: N must be odd and within 3..15");
        end
        if (CW < N + 1) begin : g_bad_cw
            $error("vote_sweep: CW must be at least N+1 to hold 2^N");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_acc_start;
    logic           w_acc_ext;
    logic           w_last;
    logic           w_y_cnt;
    logic           w_y_ext;

    logic [N:0]     r_cnt;
    logic           r_mode_q;
    logic           r_busy;
    logic           r_done;
    logic           r_y_valid;
    logic [N-1:0]   r_vec_out;
    logic           r_y_out;
    logic [CW-1:0]  r_ones_count;

    // Plain ripple sum of the input bits; synthesis is free to build a tree.
    function automatic logic [PW-1:0] popcount(input logic [N-1:0] v);
        logic [PW-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s = s + PW'(v[i]);
        end
        return s;
    endfunction

    // Minority is popcount <= T; majority is its complement (N odd, no ties).
    function automatic logic vote(input logic [N-1:0] v, input logic maj);
        return (popcount(v) <= C_T) ^ maj;
    endfunction

    // Sweep votes use the mode latched at start; single vectors use live mode.
    always_comb begin
        w_y_cnt = vote(r_cnt[N-1:0], r_mode_q);
        w_y_ext = vote(ext_vec, mode);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and request acceptance; start outranks ext_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_start = 1'b0;
        w_acc_ext   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_start = 1'b1;
                    w_state_nxt = S_SWEEP;
                end else if (ext_valid) begin
                    w_acc_ext = 1'b1;
                end
            end
            S_SWEEP: begin
                if (r_cnt == C_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: counter, tally, result registers and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_mode_q     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_y_valid    <= 1'b0;
            r_vec_out    <= '0;
            r_y_out      <= 1'b0;
            r_ones_count <= '0;
        end else begin
            r_y_valid <= 1'b0;
            r_done    <= 1'b0;
            if (w_acc_start) begin
                r_cnt        <= '0;
                r_ones_count <= '0;
                r_mode_q     <= mode;
                r_busy       <= 1'b1;
            end
            if (w_acc_ext) begin
                r_vec_out <= ext_vec;
                r_y_out   <= w_y_ext;
                r_y_valid <= 1'b1;
                r_mode_q  <= mode;
            end
            if (r_state == S_SWEEP) begin
                r_vec_out    <= r_cnt[N-1:0];
                r_y_out      <= w_y_cnt;
                r_y_valid    <= 1'b1;
                r_ones_count <= r_ones_count + CW'(w_y_cnt);
                r_cnt        <= r_cnt + C_ONE;
                if (w_last) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        busy       = r_busy;
        done       = r_done;
        y_valid    = r_y_valid;
        vec_out    = r_vec_out;
        y_out      = r_y_out;
        ones_count = r_ones_count;
    end

endmodule
